// File: rtl/console_key_seq.sv
// console_key_seq: queued console key presser. Commands (key, hold, gap) enter
// a small FIFO and are replayed one at a time as a key pulse followed by a
// release gap.
// Optional feature: define CONSOLE_KEY_SEQ_ABORT_EN to add the synchronous
// 'abort' input, which flushes the queue and returns to IDLE.
module console_key_seq #(
  parameter int unsigned NKEYS = 12,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 16,
  localparam int unsigned KW   = (NKEYS > 2) ? $clog2(NKEYS) : 1,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned FW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef CONSOLE_KEY_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [KW-1:0]    cmd_key,
  input  logic [CW-1:0]    cmd_hold,
  input  logic [CW-1:0]    cmd_gap,
  output logic [NKEYS-1:0] keys,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [FW-1:0]    fill
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    gap_q, gap_d;
  logic [NKEYS-1:0] keys_q, keys_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

  logic [KW-1:0]    mem_key_q  [DEPTH];
  logic [CW-1:0]    mem_hold_q [DEPTH];
  logic [CW-1:0]    mem_gap_q  [DEPTH];

  logic             push_c, pop_c, abort_c;
  logic [KW-1:0]    head_key_c;
  logic [CW-1:0]    head_hold_c, head_gap_c;

`ifdef CONSOLE_KEY_SEQ_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  assign head_key_c  = mem_key_q[rd_ptr_q];
  assign head_hold_c = mem_hold_q[rd_ptr_q];
  assign head_gap_c  = mem_gap_q[rd_ptr_q];

  assign cmd_ready = ready_q;
  assign keys      = keys_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign fill      = fill_q;

  // Next-state: sequencer FSM, FIFO bookkeeping and registered outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    keys_d   = keys_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pop_c    = 1'b0;
    push_c   = cmd_valid & ready_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;

    case (state_q)
      IDLE: begin
        if (fill_q != '0) begin
          pop_c = 1'b1;
          if (32'(head_key_c) >= NKEYS) begin
            // Out-of-range key: report and stay idle, nothing is pressed
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = (head_hold_c == '0) ? CW'(1) : head_hold_c;
            gap_d   = head_gap_c;
            for (int unsigned i = 0; i < NKEYS; i++) begin
              keys_d[i] = (head_key_c == KW'(i));
            end
          end
        end
      end
      HOLD: begin
        if (cnt_q <= CW'(1)) begin
          keys_d = '0;
          if (gap_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = gap_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GAP: begin
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        keys_d  = '0;
      end
    endcase

    if (abort_c) begin
      state_d = IDLE;
      keys_d  = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      pop_c   = 1'b0;
      push_c  = 1'b0;
    end

    if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_c, pop_c})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase

    if (abort_c) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end

    ready_d = (fill_d != FW'(DEPTH));
    busy_d  = (state_d != IDLE) || (fill_d != '0);
  end

  // State and output registers, cleared asynchronously by reset_n
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      keys_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      keys_q   <= keys_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Command storage; contents are only meaningful below fill
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_key_q[wr_ptr_q]  <= cmd_key;
      mem_hold_q[wr_ptr_q] <= cmd_hold;
      mem_gap_q[wr_ptr_q]  <= cmd_gap;
    end
  end

endmodule

// File: tb/tb_console_key_seq.sv
// Bench for console_key_seq: timeline reference model plus directed and
// random stimulus. Define CONSOLE_KEY_SEQ_ABORT_EN to exercise abort.
module tb_console_key_seq;

  localparam int NK    = 12;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int KW    = 4;
  localparam int FW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [KW-1:0] cmd_key = '0;
  logic [CW-1:0] cmd_hold = '0;
  logic [CW-1:0] cmd_gap = '0;
  logic [NK-1:0] keys;
  logic          busy, done, err;
  logic [FW-1:0] fill;
`ifdef CONSOLE_KEY_SEQ_ABORT_EN
  logic          abort = 1'b0;
`endif

  console_key_seq #(.NKEYS(NK), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef CONSOLE_KEY_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_key   (cmd_key),
    .cmd_hold  (cmd_hold),
    .cmd_gap   (cmd_gap),
    .keys      (keys),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .fill      (fill)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each popped command owns a window of edges
  typedef struct { logic [KW-1:0] key; int hold; int gap; } cmd_t;
  cmd_t q[$];
  int   edge_n = 0;
  int   free_edge = 0;
  int   ks = -10, ke = -10, done_e = -10;
  logic [NK-1:0] kmask = '0;
  bit   rdy_ok = 0;
  logic [NK-1:0] exp_keys = '0;
  bit   exp_done = 0, exp_err = 0, exp_busy = 0, exp_ready = 0;
  int   exp_fill = 0;

  always @(posedge clk or negedge reset_n) begin
    int e, pre, h;
    bit dn, er, ab;
    cmd_t c;
    if (!reset_n) begin
      q.delete();
      free_edge = edge_n;
      ks = -10; ke = -10; done_e = -10;
      rdy_ok = 0;
      exp_keys = '0; exp_done = 0; exp_err = 0; exp_busy = 0; exp_ready = 0; exp_fill = 0;
    end else begin
      e = edge_n; pre = q.size(); dn = 0; er = 0; ab = 0;
`ifdef CONSOLE_KEY_SEQ_ABORT_EN
      ab = abort;
`endif
      if (ab) begin
        q.delete();
        ks = -10; ke = -10; done_e = -10;
        free_edge = e + 1;
      end else begin
        if (e >= free_edge && pre > 0) begin
          c = q.pop_front();
          if (int'(c.key) >= NK) begin
            er = 1; dn = 1; free_edge = e + 1;
          end else begin
            h = (c.hold == 0) ? 1 : c.hold;
            ks = e; ke = e + h - 1;
            kmask = '0; kmask[c.key] = 1'b1;
            done_e = e + h + c.gap;
            free_edge = done_e + 1;
          end
        end
        if (done_e == e) dn = 1;
        if (cmd_valid && rdy_ok && pre < DEPTH)
          q.push_back('{cmd_key, int'(cmd_hold), int'(cmd_gap)});
      end
      exp_keys  = (e >= ks && e <= ke) ? kmask : '0;
      exp_done  = dn;
      exp_err   = er;
      exp_fill  = q.size();
      exp_ready = (q.size() < DEPTH);
      exp_busy  = (e >= ks && e < done_e) || (q.size() > 0);
      rdy_ok = 1;
      edge_n++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("keys",  32'(keys),      32'(exp_keys));
    chk("done",  32'(done),      32'(exp_done));
    chk("err",   32'(err),       32'(exp_err));
    chk("busy",  32'(busy),      32'(exp_busy));
    chk("fill",  32'(fill),      32'(exp_fill));
    chk("ready", 32'(cmd_ready), 32'(exp_ready));
  end

  task automatic set_cmd(input int k, input int h, input int g);
    cmd_valid = 1'b1;
    cmd_key   = KW'(k);
    cmd_hold  = CW'(h);
    cmd_gap   = CW'(g);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) return;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_keys",  32'(keys), 32'(0));
    chk("rst_ready", 32'(cmd_ready), 32'(0));
    chk("rst_fill",  32'(fill), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 32'(1));

    // Basic press: key 1, hold 3, gap 2
    set_cmd(1, 3, 2);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b_fill", 32'(fill), 32'(1));
    chk("b_keys0", 32'(keys), 32'(0));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("b_keys_on", 32'(keys), 32'h002);
    end
    @(negedge clk);
    chk("b_keys_off", 32'(keys), 32'(0));
    @(negedge clk);
    chk("b_gap_done", 32'(done), 32'(0));
    chk("b_gap_busy", 32'(busy), 32'(1));
    @(negedge clk);
    chk("b_done", 32'(done), 32'(1));
    @(negedge clk);
    chk("b_done_end", 32'(done), 32'(0));
    chk("b_busy_end", 32'(busy), 32'(0));

    // Minimum press (hold 0, gap 0) followed by another command
    wait_idle();
    set_cmd(0, 0, 0);
    @(negedge clk);
    set_cmd(5, 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("m_key0", 32'(keys), 32'h001);
    @(negedge clk);
    chk("m_gapless", 32'(keys), 32'(0));
    chk("m_done", 32'(done), 32'(1));
    @(negedge clk);
    chk("m_next", 32'(keys), 32'h020);

    // Invalid key then valid key
    wait_idle();
    set_cmd(13, 2, 0);
    @(negedge clk);
    set_cmd(3, 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("i_err", 32'(err), 32'(1));
    chk("i_done", 32'(done), 32'(1));
    chk("i_keys", 32'(keys), 32'(0));
    @(negedge clk);
    chk("i_next", 32'(keys), 32'h008);
    chk("i_err_end", 32'(err), 32'(0));

    // FIFO full back-pressure behind a long press
    wait_idle();
    set_cmd(2, 20, 0);
    @(negedge clk);
    set_cmd(4, 1, 1);
    repeat (4) @(negedge clk);
    chk("f_fill", 32'(fill), 32'(4));
    chk("f_ready", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    chk("f_held", 32'(fill), 32'(4));
    for (int i = 0; i < 40; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (!cmd_ready) chk("f_ready_timeout", 32'(cmd_ready), 32'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_idle();

    // Reset during a long press with one queued command
    set_cmd(7, 100, 0);
    @(negedge clk);
    set_cmd(9, 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("r_keys_pre", 32'(keys), 32'h080);
    chk("r_fill_pre", 32'(fill), 32'(1));
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("r_keys_async", 32'(keys), 32'(0));
    chk("r_fill_async", 32'(fill), 32'(0));
    chk("r_busy_async", 32'(busy), 32'(0));
    chk("r_ready_async", 32'(cmd_ready), 32'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_cmd(9, 1, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("r_after", 32'(keys), 32'h200);
    wait_idle();

`ifdef CONSOLE_KEY_SEQ_ABORT_EN
    // Abort during GAP with three commands queued
    set_cmd(2, 1, 5);
    @(negedge clk);
    set_cmd(3, 1, 0);
    repeat (3) @(negedge clk);
    chk("a_fill_pre", 32'(fill), 32'(3));
    cmd_valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("a_fill", 32'(fill), 32'(0));
    chk("a_busy", 32'(busy), 32'(0));
    chk("a_done", 32'(done), 32'(0));
    chk("a_keys", 32'(keys), 32'(0));
    wait_idle();
`endif

    // Randomized traffic with one mid-run reset
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_key   = KW'($urandom_range(0, 15));
      cmd_hold  = CW'($urandom_range(0, 5));
      cmd_gap   = CW'($urandom_range(0, 3));
`ifdef CONSOLE_KEY_SEQ_ABORT_EN
      abort = ($urandom_range(0, 49) == 0);
`endif
      if (cyc == 700) #2 reset_n = 1'b0;
      if (cyc == 703) #2 reset_n = 1'b1;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef CONSOLE_KEY_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    wait_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/console_key_seq.md
CONSOLE_KEY_SEQ -- requirements
Module: console_key_seq

Interface
REQ-001 SHALL have parameter NKEYS, default 12, number of console key outputs (start, read_in, mem_cont, ...).
REQ-002 SHALL have parameter DEPTH, default 4, command FIFO entries, power of two, >=2.
REQ-003 SHALL have parameter CW, default 16, width of hold/gap counts.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command offered.
REQ-007 SHALL have port cmd_ready  output  1  FIFO can accept; high iff FIFO not full.
REQ-008 SHALL have port cmd_key  input  KW=max(1,clog2(NKEYS))  key index to press.
REQ-009 SHALL have port cmd_hold  input  CW  key-asserted cycles.
REQ-010 SHALL have port cmd_gap  input  CW  release cycles after key drops.
REQ-011 SHALL have port keys  output  NKEYS  key levels, at most one bit high.
REQ-012 SHALL have port busy  output  1  high when state != IDLE or FIFO non-empty.
REQ-013 SHALL have port done  output  1  one-cycle pulse at completion of each command.
REQ-014 SHALL have port err  output  1  one-cycle pulse when a popped command has cmd_key >= NKEYS.
REQ-015 SHALL have port fill  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-016 SHALL accept a command on a rising edge with cmd_valid & cmd_ready; cmd_ready SHALL depend only on registered FIFO state.
REQ-017 SHALL allow push and pop on the same edge; fill unchanged; full FIFO refuses push even if popping that edge.
REQ-018 SHALL wrap FIFO read/write pointers modulo DEPTH; commands execute in acceptance order.
REQ-019 SHALL implement states IDLE, HOLD, GAP.
REQ-020 IDLE with FIFO non-empty: pop on next edge, load counter with max(cmd_hold,1), enter HOLD, drive keys[cmd_key] high from that edge (command accepted into empty FIFO at edge N -> key high after edge N+1).
REQ-021 HOLD: key held exactly max(cmd_hold,1) cycles; at expiry key drops same edge, enter GAP with counter=cmd_gap, or IDLE if cmd_gap=0.
REQ-022 GAP: keys all zero for exactly cmd_gap cycles, then IDLE.
REQ-023 done SHALL pulse in the cycle after the key drops when cmd_gap=0, else the cycle after GAP ends; back-to-back commands add one IDLE cycle between them.
REQ-024 Popped command with cmd_key >= NKEYS: no key asserted, err and done pulse together next cycle, state stays IDLE.
REQ-025 Counters CW bits, unsigned, no overflow possible (load-and-decrement only).

Reset
REQ-026 reset_n low SHALL immediately clear keys=0, cmd_ready=0, busy=0, done=0, err=0, fill=0, state=IDLE, pointers=0, regardless of clk.
REQ-027 Reset mid-HOLD SHALL drop the key asynchronously and discard all queued commands; cmd_ready high from first edge after release.

Configuration
REQ-028 Macro CONSOLE_KEY_SEQ_ABORT_EN defined: adds input abort (1 bit); abort high at an edge SHALL clear FIFO, force IDLE, zero keys that edge, no done pulse; push on same edge ignored.
REQ-029 Macro undefined: no abort port; only reset_n clears operation.

Verification
REQ-030 Reset, push key=1 hold=3 gap=2 at edge 0 -> keys=0x002 edges 1..4 (3 cycles), GAP 2 cycles, done pulse 1 cycle, busy low afterward.
REQ-031 Push 5 commands (DEPTH=4) with key never starting -> cmd_ready low after 4th acceptance, fill=4, 5th held until first pop.
REQ-032 hold=0 gap=0 key=0 -> keys[0] high exactly 1 cycle, done next cycle, one IDLE cycle before next command's key.
REQ-033 cmd_key=13 with NKEYS=12 -> keys stay 0, err and done pulse once, following valid command executes normally.
REQ-034 Assert reset_n low mid-HOLD of hold=100 -> keys 0 without clock edge, fill=0; after release new command executes from IDLE.
REQ-035 With CONSOLE_KEY_SEQ_ABORT_EN, abort during GAP with 3 queued -> IDLE next edge, fill=0, no done, busy low.
